alu_operand_sequencer: RTL

Execute-stage sequencer that sits directly upstream of the 16-bit logic unit and consumes what it produces. It owns an 8x16 register file and accepts one decoded instruction per valid/ready handshake. It drives the unit's one-hot operation lines and bus1/bus2, captures bus3, writes the result back, and updates zero/negative flags. Fixed 4-cycle instruction latency; one instruction in flight.

---
 rtl/alu_operand_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Execute-stage sequencer placed in front of a 16-bit logic unit. Each
// instruction accepted on the valid/ready handshake passes through
// IDLE -> READ -> EXEC -> WRITE. The sequencer fetches operands from its
// register file onto bus1/bus2, raises one logic-unit control line during
// EXEC, captures bus3 and writes the result back with zero/negative flags.
//
// Ports:
//   clk, rst                          clock (rising edge), async active-high reset
//   instr_valid / instr_ready         instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2/imm/use_imm   decoded instruction fields
//   passthrough..bnegate              logic-unit controls, one-hot or all zero
//   bus1, bus2                        operands to the logic unit (held until next READ)
//   bus3                              result from the logic unit (sampled only in EXEC)
//   result, zero_flag, neg_flag       last captured result and its flags
//   done, illegal                     one-cycle completion / illegal-opcode pulses
//   dbg_addr, dbg_data                combinational register-file peek
module alu_operand_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_imm,
  output logic              passthrough,
  output logic              add,
  output logic              sub,
  output logic              shr,
  output logic              shl,
  output logic              band,
  output logic              bor,
  output logic              bxor,
  output logic              bnegate,
  output logic [DATA_W-1:0] bus1,
  output logic [DATA_W-1:0] bus2,
  input  logic [DATA_W-1:0] bus3,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              neg_flag,
  output logic              done,
  output logic              illegal,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_LDI = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        op_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic [ADDR_W-1:0] rs1_reg;
  logic [ADDR_W-1:0] rs2_reg;
  logic [DATA_W-1:0] imm_reg;
  logic              use_imm_reg;
  logic [8:0]        ctrl_reg;
  logic              op_legal;
  logic [DATA_W-1:0] regfile [NREGS];

  // Control-line bit order: {bnegate, bxor, bor, band, shl, shr, sub, add, passthrough}.
  // Load-immediate reuses passthrough; illegal opcodes drive nothing.
  function automatic logic [8:0] decode_op(input logic [3:0] o);
    logic [8:0] v;
    v = '0;
    case (o)
      4'd0:    v = 9'b0_0000_0001;
      4'd1:    v = 9'b0_0000_0010;
      4'd2:    v = 9'b0_0000_0100;
      4'd3:    v = 9'b0_0000_1000;
      4'd4:    v = 9'b0_0001_0000;
      4'd5:    v = 9'b0_0010_0000;
      4'd6:    v = 9'b0_0100_0000;
      4'd7:    v = 9'b0_1000_0000;
      4'd8:    v = 9'b1_0000_0000;
      4'd9:    v = 9'b0_0000_0001;
      default: v = 9'b0_0000_0000;
    endcase
    return v;
  endfunction

  assign op_legal    = (op_reg <= OP_LDI);
  assign instr_ready = (state == IDLE);
  assign dbg_data    = regfile[dbg_addr];

  assign passthrough = ctrl_reg[0];
  assign add         = ctrl_reg[1];
  assign sub         = ctrl_reg[2];
  assign shr         = ctrl_reg[3];
  assign shl         = ctrl_reg[4];
  assign band        = ctrl_reg[5];
  assign bor         = ctrl_reg[6];
  assign bxor        = ctrl_reg[7];
  assign bnegate     = ctrl_reg[8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_reg      <= '0;
      rd_reg      <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      imm_reg     <= '0;
      use_imm_reg <= 1'b0;
      ctrl_reg    <= '0;
      bus1        <= '0;
      bus2        <= '0;
      result      <= '0;
      zero_flag   <= 1'b0;
      neg_flag    <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regfile[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_reg      <= instr_op;
            rd_reg      <= instr_rd;
            rs1_reg     <= instr_rs1;
            rs2_reg     <= instr_rs2;
            imm_reg     <= instr_imm;
            use_imm_reg <= instr_use_imm;
            state       <= READ;
          end
        end
        READ: begin
          // Operands come from the register file as it stands after the
          // previous WRITE, so dependent instructions see fresh values.
          bus1     <= (op_reg == OP_LDI) ? imm_reg : regfile[rs1_reg];
          bus2     <= use_imm_reg ? imm_reg : regfile[rs2_reg];
          ctrl_reg <= decode_op(op_reg);
          state    <= EXEC;
        end
        EXEC: begin
          // bus3 may float for illegal ops, so it is only captured when a
          // control line was actually driven.
          if (op_legal) begin
            result <= bus3;
          end
          ctrl_reg <= '0;
          done     <= 1'b1;
          illegal  <= ~op_legal;
          state    <= WRITE;
        end
        WRITE: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          if (op_legal) begin
            regfile[rd_reg] <= result;
            zero_flag       <= (result == '0);
            neg_flag        <= result[DATA_W-1];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
